cpu_trace_buffer: RTL

- Parametrised hardware retirement-trace capture unit for the single-cycle CPU; replaces the per-cycle print monitor with on-chip, synthesizable capture.
- Records {PC, instruction, register write data, zero flag} for every retired instruction into a circular buffer of DEPTH entries.
- Supports a PC-match trigger with programmable post-trigger count, then freezes the buffer and streams entries out oldest-first through a request/valid readout port.

---
 rtl/cpu_trace_pkg.sv | 34 +++
 rtl/cpu_trace_buffer_ram.sv | 42 ++++
 rtl/cpu_trace_buffer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_trace_pkg.sv
// cpu_trace_pkg: shared definitions for the retirement-trace capture unit.
//   - trace_state_t : capture/readout FSM encoding (IDLE/ARMED/POST/DONE)
//   - entry_w()     : width of one packed trace entry for a given XLEN
//   - *_off()       : bit offsets of each field inside a packed entry
// Entry layout, LSB first: zero flag, write data, instruction word, PC.
package cpu_trace_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } trace_state_t;

    localparam int INSTR_W   = 32;
    localparam int ZERO_OFF  = 0;
    localparam int WDATA_OFF = 1;

    // Total entry width: PC + write data + instruction + zero flag.
    function automatic int entry_w(input int xlen);
        return 2 * xlen + INSTR_W + 1;
    endfunction

    // Instruction word sits directly above the write data.
    function automatic int instr_off(input int xlen);
        return WDATA_OFF + xlen;
    endfunction

    // PC occupies the top XLEN bits.
    function automatic int pc_off(input int xlen);
        return WDATA_OFF + xlen + INSTR_W;
    endfunction

endpackage

// File: rtl/cpu_trace_buffer_ram.sv
// trace_ram: simple dual-port synchronous RAM, DEPTH x W.
// Ports:
//   clk              clock
//   wr_en/wr_addr/wr_data   write port, written on the rising edge
//   rd_en/rd_addr           read request
//   rd_data          registered read data, valid the cycle after rd_en
// The read register holds its value while rd_en is low. Contents are not
// reset; the owner qualifies rd_data with its own valid flag.
module trace_ram #(
    parameter int DEPTH = 64,
    parameter int W     = 97,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem_r [DEPTH];
    logic [W-1:0] rd_data_r;

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer: retirement-trace capture unit with PC-match trigger.
// Captures {pc, instr, wdata, zero} for every retired instruction into a
// circular buffer, freezes after trigger + post count, then streams the
// entries out oldest-first.
// Ports:
//   clk, start                  clock; synchronous active-high reset
//   valid_i, pc_i, instr_i,
//   wdata_i, zero_i             retirement record to capture
//   arm_i                       clear buffer and start capture
//   trig_en_i, trig_pc_i,
//   post_cnt_i                  trigger control
//   rd_req_i                    pop one entry (DONE only)
//   rd_valid_o, rd_pc_o, rd_instr_o, rd_wdata_o, rd_zero_o, rd_last_o
//                               popped entry, one cycle after the request
//   state_o, fill_o             FSM state and number of valid entries
module cpu_trace_buffer
    import cpu_trace_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            start,
    input  logic            valid_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic            zero_i,
    input  logic            arm_i,
    input  logic            trig_en_i,
    input  logic [XLEN-1:0] trig_pc_i,
    input  logic [AW-1:0]   post_cnt_i,
    input  logic            rd_req_i,
    output logic            rd_valid_o,
    output logic [XLEN-1:0] rd_pc_o,
    output logic [31:0]     rd_instr_o,
    output logic [XLEN-1:0] rd_wdata_o,
    output logic            rd_zero_o,
    output logic            rd_last_o,
    output logic [1:0]      state_o,
    output logic [AW:0]     fill_o
);

    localparam int ENTRY_W = entry_w(XLEN);
    localparam int INS_OFF = instr_off(XLEN);
    localparam int PC_OFF  = pc_off(XLEN);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   FILL_ONE = (AW+1)'(1);
    localparam logic [AW:0]   FILL_MAX = (AW+1)'(DEPTH);

    trace_state_t       state_r;
    logic [AW-1:0]      wr_ptr_r;
    logic [AW:0]        fill_r;
    logic [AW-1:0]      post_r;
    logic               rd_valid_r;
    logic               rd_last_r;

    logic               wr_s;
    logic               pop_s;
    logic               trig_hit_s;
    logic [AW-1:0]      rd_addr_s;
    logic [ENTRY_W-1:0] wentry_s;
    logic [ENTRY_W-1:0] rentry_s;

    // Write/pop strobes and the oldest-entry address. Oldest stays equal to
    // wr_ptr - fill across pops, so no separate read pointer is kept.
    always_comb begin
        wr_s       = valid_i && !start && (state_r == ARMED || state_r == POST);
        pop_s      = rd_req_i && !start && !arm_i && (state_r == DONE) && (fill_r != '0);
        trig_hit_s = valid_i && trig_en_i && (pc_i == trig_pc_i);
        rd_addr_s  = wr_ptr_r - fill_r[AW-1:0];
    end

    // Pack the retiring record into one RAM word.
    always_comb begin
        wentry_s                        = '0;
        wentry_s[ZERO_OFF]              = zero_i;
        wentry_s[WDATA_OFF +: XLEN]     = wdata_i;
        wentry_s[INS_OFF   +: INSTR_W]  = instr_i;
        wentry_s[PC_OFF    +: XLEN]     = pc_i;
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_s),
        .wr_addr (wr_ptr_r),
        .wr_data (wentry_s),
        .rd_en   (pop_s),
        .rd_addr (rd_addr_s),
        .rd_data (rentry_s)
    );

    // Capture/readout FSM with pointer, fill and post-trigger counters.
    always_ff @(posedge clk) begin
        if (start) begin
            state_r    <= IDLE;
            wr_ptr_r   <= '0;
            fill_r     <= '0;
            post_r     <= '0;
            rd_valid_r <= 1'b0;
            rd_last_r  <= 1'b0;
        end else begin
            rd_valid_r <= pop_s;
            rd_last_r  <= pop_s && (fill_r == FILL_ONE);
            case (state_r)
                IDLE: begin
                    if (arm_i) begin
                        state_r  <= ARMED;
                        wr_ptr_r <= '0;
                        fill_r   <= '0;
                        post_r   <= '0;
                    end
                end
                ARMED: begin
                    if (valid_i) begin
                        wr_ptr_r <= wr_ptr_r + PTR_ONE;
                        if (fill_r != FILL_MAX) begin
                            fill_r <= fill_r + FILL_ONE;
                        end
                        if (trig_hit_s) begin
                            if (post_cnt_i == '0) begin
                                state_r <= DONE;
                            end else begin
                                post_r  <= post_cnt_i;
                                state_r <= POST;
                            end
                        end
                    end
                end
                POST: begin
                    if (valid_i) begin
                        wr_ptr_r <= wr_ptr_r + PTR_ONE;
                        if (fill_r != FILL_MAX) begin
                            fill_r <= fill_r + FILL_ONE;
                        end
                        post_r <= post_r - PTR_ONE;
                        if (post_r == PTR_ONE) begin
                            state_r <= DONE;
                        end
                    end
                end
                DONE: begin
                    // arm_i beats a same-cycle pop; an empty buffer drains to IDLE
                    // in the cycle the final entry is presented.
                    if (arm_i) begin
                        state_r  <= ARMED;
                        wr_ptr_r <= '0;
                        fill_r   <= '0;
                        post_r   <= '0;
                    end else if (pop_s) begin
                        fill_r <= fill_r - FILL_ONE;
                    end else if (fill_r == '0) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Readout fields, forced to zero outside a valid pulse.
    always_comb begin
        if (rd_valid_r) begin
            rd_pc_o    = rentry_s[PC_OFF    +: XLEN];
            rd_instr_o = rentry_s[INS_OFF   +: INSTR_W];
            rd_wdata_o = rentry_s[WDATA_OFF +: XLEN];
            rd_zero_o  = rentry_s[ZERO_OFF];
        end else begin
            rd_pc_o    = '0;
            rd_instr_o = '0;
            rd_wdata_o = '0;
            rd_zero_o  = 1'b0;
        end
    end

    assign rd_valid_o = rd_valid_r;
    assign rd_last_o  = rd_last_r;
    assign state_o    = state_r;
    assign fill_o     = fill_r;

endmodule
